// File: rtl/percep_wght_seq.sv
// Weight-memory sequencer for the perceptron: LOAD fetches w0..w(ATTR-1) into a
// parallel vector, WRITEBACK stores an updated vector one word per cycle.
module percep_wght_seq #(
    parameter int unsigned ATTR          = 5,
    parameter int unsigned MEM_ADDR_WGHT = 3,
    parameter int unsigned FP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic                       wb_req,
    input  logic [ATTR*FP_WIDTH-1:0]   wght_new,
    output logic [ATTR*FP_WIDTH-1:0]   wght_vec,
    output logic                       load_done,
    output logic                       wb_done,
    output logic                       busy,
    output logic                       mem_cs,
    output logic                       mem_we,
    output logic                       mem_oe,
    output logic [MEM_ADDR_WGHT-1:0]   mem_addr,
    output logic [FP_WIDTH-1:0]        mem_din,
    input  logic [FP_WIDTH-1:0]        mem_dout
);

    localparam int unsigned CNT_W = (ATTR > 1) ? $clog2(ATTR) : 1;
    localparam int unsigned VEC_W = ATTR * FP_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ATTR - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_pend_q, load_pend_d;
    logic [VEC_W-1:0]  shadow_q, shadow_d;
    logic [VEC_W-1:0]  wght_vec_q, wght_vec_d;
    logic              load_done_q, load_done_d;
    logic              wb_done_q, wb_done_d;
    logic [FP_WIDTH-1:0] shadow_word;

    assign wght_vec  = wght_vec_q;
    assign load_done = load_done_q;
    assign wb_done   = wb_done_q;
    assign busy      = (state_q != ST_IDLE);

    // Select the shadow word addressed by cnt for writeback data
    always_comb begin
        shadow_word = '0;
        for (int unsigned i = 0; i < ATTR; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                shadow_word = shadow_q[i*FP_WIDTH +: FP_WIDTH];
            end
        end
    end

    // Memory port drive, decoded from state and word index
    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state_q)
            ST_LOAD: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = MEM_ADDR_WGHT'(cnt_q);
            end
            ST_WB: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = MEM_ADDR_WGHT'(cnt_q);
                mem_din  = shadow_word;
            end
            default: ;
        endcase
    end

    // Next-state, word index, pending-load slot and data capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_pend_d = load_pend_q;
        shadow_d    = shadow_q;
        wght_vec_d  = wght_vec_q;
        load_done_d = 1'b0;
        wb_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    // Writeback wins; a simultaneous load is replayed afterwards
                    shadow_d = wght_new;
                    cnt_d    = '0;
                    state_d  = ST_WB;
                    if (load_req) begin
                        load_pend_d = 1'b1;
                    end
                end else if (load_req || load_pend_q) begin
                    load_pend_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_req) begin
                    load_pend_d = 1'b1;
                end
                for (int unsigned i = 0; i < ATTR; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        wght_vec_d[i*FP_WIDTH +: FP_WIDTH] = mem_dout;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                if (load_req) begin
                    load_pend_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    wb_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            shadow_q    <= '0;
            wght_vec_q  <= '0;
            load_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_pend_q <= load_pend_d;
            shadow_q    <= shadow_d;
            wght_vec_q  <= wght_vec_d;
            load_done_q <= load_done_d;
            wb_done_q   <= wb_done_d;
        end
    end

endmodule

// File: tb/tb_percep_wght_seq.sv
// Directed bench for percep_wght_seq with a behavioural 8 x 16 weight memory.
module tb_percep_wght_seq;

    localparam int unsigned ATTR = 5;
    localparam int unsigned AW   = 3;
    localparam int unsigned FW   = 16;

    logic                 clk;
    logic                 rst;
    logic                 load_req;
    logic                 wb_req;
    logic [ATTR*FW-1:0]   wght_new;
    logic [ATTR*FW-1:0]   wght_vec;
    logic                 load_done;
    logic                 wb_done;
    logic                 busy;
    logic                 mem_cs;
    logic                 mem_we;
    logic                 mem_oe;
    logic [AW-1:0]        mem_addr;
    logic [FW-1:0]        mem_din;
    logic [FW-1:0]        mem_dout;

    logic [FW-1:0] mem [8];

    int errors;
    int checks;

    percep_wght_seq #(.ATTR(ATTR), .MEM_ADDR_WGHT(AW), .FP_WIDTH(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .wb_req   (wb_req),
        .wght_new (wght_new),
        .wght_vec (wght_vec),
        .load_done(load_done),
        .wb_done  (wb_done),
        .busy     (busy),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: combinational read, write on clock edge
    assign mem_dout = (mem_cs && mem_oe) ? mem[mem_addr] : '0;
    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_din;
    end

    typedef struct {
        logic          ld;
        logic          wb;
        logic          busy;
        logic          cs;
        logic          oe;
        logic          we;
        logic [AW-1:0] addr;
        logic [FW-1:0] din;
        logic          ldd;
        logic          wbd;
    } vec_t;

    vec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] mem_rows04();
        return {mem[4], mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic wait_load_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (load_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_wb_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (wb_done) begin
                n = i;
                break;
            end
        end
    endtask

    localparam logic [79:0] V1 = 80'h0005_0004_0003_0002_0001;
    localparam logic [79:0] V2 = 80'h1111_2222_3333_4444_5555;
    localparam logic [79:0] V3 = 80'hDEAD_BEEF_0BAD_F00D_CAFE;
    localparam logic [79:0] V4 = 80'hA004_A003_A002_A001_A000;

    initial begin
        int n;
        int n_ld;
        int n_we;
        int n_wbd;
        int n_cs;
        logic [24:0] act_row;
        logic [24:0] exp_row;

        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        load_req = 1'b0;
        wb_req   = 1'b0;
        wght_new = '0;
        mem[0] = 16'h3C00; mem[1] = 16'h3800; mem[2] = 16'h3400; mem[3] = 16'h3000;
        mem[4] = 16'h2C00; mem[5] = 16'h0055; mem[6] = 16'h0066; mem[7] = 16'h0077;

        // Rows: check outputs of the current cycle, then apply ld/wb for the next edge
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0002, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0003, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0004, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0005, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};

        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("reset_outputs", 128'({busy, mem_cs, mem_we, mem_oe, mem_addr, mem_din, load_done, wb_done}), 128'd0);
        chk("reset_wght_vec", 128'(wght_vec), 128'd0);

        // LOAD then WRITEBACK, cycle by cycle
        wght_new = V1;
        for (int i = 0; i < 15; i++) begin
            act_row = {busy, mem_cs, mem_oe, mem_we, mem_addr, mem_din, load_done, wb_done};
            exp_row = {tbl[i].busy, tbl[i].cs, tbl[i].oe, tbl[i].we, tbl[i].addr,
                       tbl[i].din, tbl[i].ldd, tbl[i].wbd};
            chk($sformatf("row%0d", i), 128'(act_row), 128'(exp_row));
            load_req = tbl[i].ld;
            wb_req   = tbl[i].wb;
            tick();
        end
        chk("load_vec_held", 128'(wght_vec), 128'(80'h2C00_3000_3400_3800_3C00));
        chk("wb_mem_rows", 128'(mem_rows04()), 128'(V1));

        // Follow-up load returns the written vector
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_load_done(20, n);
        chk("reload_latency", 128'(n), 128'(5));
        chk("reload_vec", 128'(wght_vec), 128'(V1));
        chk("rows567_kept", 128'({mem[7], mem[6], mem[5]}), 128'(48'h0077_0066_0055));

        // Simultaneous load_req and wb_req: WB, one IDLE cycle, then LOAD
        tick();
        wght_new = V2;
        load_req = 1'b1;
        wb_req   = 1'b1;
        tick();
        load_req = 1'b0;
        wb_req   = 1'b0;
        wght_new = V3;
        wait_wb_done(20, n);
        chk("both_wb_latency", 128'(n), 128'(5));
        chk("both_idle_gap", 128'({busy, mem_cs}), 128'(2'b00));
        tick();
        chk("both_auto_load", 128'({busy, mem_oe, mem_we, mem_addr}), 128'(6'b110_000));
        wait_load_done(20, n);
        chk("both_load_latency", 128'(n), 128'(5));
        chk("both_vec", 128'(wght_vec), 128'(V2));

        // Requests during LOAD: wb ignored, repeated load_req collapse to one extra LOAD
        tick();
        load_req = 1'b1;
        tick();
        wb_req   = 1'b1;
        wght_new = V4;
        tick();
        wb_req   = 1'b0;
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        n_ld = 0; n_we = 0; n_wbd = 0;
        for (int i = 0; i < 40; i++) begin
            if (load_done) n_ld++;
            if (mem_we)    n_we++;
            if (wb_done)   n_wbd++;
            tick();
        end
        chk("busy_load_count", 128'(n_ld), 128'(2));
        chk("busy_no_write", 128'({n_we, n_wbd}), 128'd0);
        chk("busy_mem_rows", 128'(mem_rows04()), 128'(V2));
        chk("busy_vec", 128'(wght_vec), 128'(V2));

        // Reset during the third WB cycle
        wght_new = V4;
        wb_req   = 1'b1;
        tick();
        wb_req   = 1'b0;
        tick();
        tick();
        chk("wb3_addr", 128'({mem_we, mem_addr}), 128'(4'b1_010));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_wb_ports", 128'({busy, mem_cs, mem_we, mem_oe, mem_addr, mem_din, wb_done, load_done}), 128'd0);
        chk("rst_mid_wb_vec", 128'(wght_vec), 128'd0);
        n_cs = 0; n_wbd = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_cs)  n_cs++;
            if (wb_done) n_wbd++;
            tick();
        end
        chk("idle_cs_quiet", 128'(n_cs), 128'd0);
        chk("rst_no_wb_done", 128'(n_wbd), 128'd0);
        chk("rst_partial_rows", 128'(mem_rows04()), 128'(80'h1111_2222_A002_A001_A000));
        chk("rst_rows567", 128'({mem[7], mem[6], mem[5]}), 128'(48'h0077_0066_0055));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
